// File: rtl/pipe_frame_painter_if.sv
// Pixel-stream bundle between the game-state logic (master) and the frame painter (slave).
// The master supplies positions and frame requests; the painter returns pixels and status.
interface pipe_frame_painter_if #(
  parameter int NUM_PIPES = 2
);
  logic                   game_pulse;
  logic [6:0]             box_y;
  logic [8*NUM_PIPES-1:0] pipe_x;
  logic [7*NUM_PIPES-1:0] pipe_gap_y;
  logic                   plot;
  logic [7:0]             x;
  logic [6:0]             y;
  logic [2:0]             colour;
  logic                   busy;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output game_pulse, box_y, pipe_x, pipe_gap_y,
    input  plot, x, y, colour, busy, frame_done, overrun
  );

  modport slave (
    input  game_pulse, box_y, pipe_x, pipe_gap_y,
    output plot, x, y, colour, busy, frame_done, overrun
  );
endinterface

// File: rtl/pipe_frame_painter.sv
// Per game tick: erase the previous bird box and pipes, latch new positions, draw the new frame.
// One pixel per clock; pixel outputs are registered one cycle behind the scan counters.
module pipe_frame_painter #(
  parameter int NUM_PIPES = 2,
  parameter int PIPE_W    = 4,
  parameter int GAP_H     = 32,
  parameter int BOX_SIZE  = 3,
  parameter int BOX_X     = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120
) (
  input logic                CLOCK_50,
  input logic                resetn,
  pipe_frame_painter_if.slave gfx
);
  localparam int PIDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  typedef enum logic [2:0] {
    IDLE, ERASE_BOX, ERASE_PIPES, LATCH, DRAW_BOX, DRAW_PIPES, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        row_reg, row_next;
  logic [7:0]        col_reg, col_next;
  logic [PIDX_W-1:0] pipe_reg, pipe_next;

  logic              prev_valid_reg;
  logic [6:0]        prev_box_y_reg;
  logic [7:0]        prev_px_reg [NUM_PIPES];
  logic [6:0]        prev_gy_reg [NUM_PIPES];
  logic [7:0]        pipe_x_in   [NUM_PIPES];
  logic [6:0]        pipe_gy_in  [NUM_PIPES];

  logic              plot_reg;
  logic [7:0]        x_reg;
  logic [6:0]        y_reg;
  logic [2:0]        colour_reg;
  logic              frame_done_reg;
  logic              overrun_reg;

  logic              box_last, pipe_last;
  logic              scanning, is_draw, in_gap, scan_plot;
  logic [8:0]        scan_x;
  logic [7:0]        scan_y;
  logic [2:0]        scan_colour;
  logic [7:0]        cur_px, gap_lo, gap_hi;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_unpack
      assign pipe_x_in[gi]  = gfx.pipe_x[8*gi +: 8];
      assign pipe_gy_in[gi] = gfx.pipe_gap_y[7*gi +: 7];
    end
  endgenerate

  assign box_last  = (row_reg == 8'(BOX_SIZE-1)) && (col_reg == 8'(BOX_SIZE-1));
  assign pipe_last = (pipe_reg == PIDX_W'(NUM_PIPES-1)) && (col_reg == 8'(PIPE_W-1)) &&
                     (row_reg == 8'(SCREEN_H-1));

  // Counters are parked at zero outside the scan phases, so each scan starts clean.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    pipe_next  = pipe_reg;
    case (state_reg)
      IDLE: begin
        if (gfx.game_pulse) state_next = prev_valid_reg ? ERASE_BOX : LATCH;
      end
      ERASE_BOX, DRAW_BOX: begin
        if (box_last) begin
          row_next   = '0;
          col_next   = '0;
          state_next = (state_reg == ERASE_BOX) ? ERASE_PIPES : DRAW_PIPES;
        end else if (col_reg == 8'(BOX_SIZE-1)) begin
          col_next = '0;
          row_next = row_reg + 8'd1;
        end else begin
          col_next = col_reg + 8'd1;
        end
      end
      ERASE_PIPES, DRAW_PIPES: begin
        if (pipe_last) begin
          row_next   = '0;
          col_next   = '0;
          pipe_next  = '0;
          state_next = (state_reg == ERASE_PIPES) ? LATCH : DONE;
        end else if (row_reg == 8'(SCREEN_H-1)) begin
          row_next = '0;
          if (col_reg == 8'(PIPE_W-1)) begin
            col_next  = '0;
            pipe_next = pipe_reg + PIDX_W'(1);
          end else begin
            col_next = col_reg + 8'd1;
          end
        end else begin
          row_next = row_reg + 8'd1;
        end
      end
      LATCH:   state_next = DRAW_BOX;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Erase and draw both read the prev registers; erase simply runs before LATCH overwrites them.
  always_comb begin
    scanning    = 1'b0;
    scan_x      = '0;
    scan_y      = '0;
    scan_colour = 3'b000;
    is_draw     = (state_reg == DRAW_BOX) || (state_reg == DRAW_PIPES);
    cur_px      = prev_px_reg[pipe_reg];
    gap_lo      = {1'b0, prev_gy_reg[pipe_reg]};
    gap_hi      = gap_lo + 8'(GAP_H-1);
    in_gap      = (row_reg >= gap_lo) && (row_reg <= gap_hi);
    case (state_reg)
      ERASE_BOX, DRAW_BOX: begin
        scanning    = 1'b1;
        scan_x      = 9'(BOX_X) + {1'b0, col_reg};
        scan_y      = {1'b0, prev_box_y_reg} + row_reg;
        scan_colour = is_draw ? 3'b110 : 3'b000;
      end
      ERASE_PIPES, DRAW_PIPES: begin
        scanning    = 1'b1;
        scan_x      = {1'b0, cur_px} + {1'b0, col_reg};
        scan_y      = row_reg;
        scan_colour = (is_draw && !in_gap) ? 3'b010 : 3'b000;
      end
      default: ;
    endcase
    scan_plot = scanning && (scan_x < 9'(SCREEN_W)) && (scan_y < 8'(SCREEN_H));
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      pipe_reg       <= '0;
      prev_valid_reg <= 1'b0;
      prev_box_y_reg <= '0;
      prev_px_reg    <= '{default: '0};
      prev_gy_reg    <= '{default: '0};
      plot_reg       <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      colour_reg     <= '0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      pipe_reg       <= pipe_next;
      plot_reg       <= scan_plot;
      x_reg          <= scan_x[7:0];
      y_reg          <= scan_y[6:0];
      colour_reg     <= scan_colour;
      frame_done_reg <= (state_reg == DONE);
      overrun_reg    <= gfx.game_pulse && (state_reg != IDLE);
      if (state_reg == LATCH) begin
        prev_valid_reg <= 1'b1;
        prev_box_y_reg <= gfx.box_y;
        prev_px_reg    <= pipe_x_in;
        prev_gy_reg    <= pipe_gy_in;
      end
    end
  end

  assign gfx.plot       = plot_reg;
  assign gfx.x          = x_reg;
  assign gfx.y          = y_reg;
  assign gfx.colour     = colour_reg;
  assign gfx.busy       = (state_reg != IDLE);
  assign gfx.frame_done = frame_done_reg;
  assign gfx.overrun    = overrun_reg;
endmodule

// File: tb/tb_pipe_frame_painter.sv
// Directed bench for pipe_frame_painter: captures whole frames cycle by cycle and compares
// them against an expected pixel stream built from the frame description.
module tb_pipe_frame_painter;
  localparam int NCAP = 2048;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  pipe_frame_painter_if #(.NUM_PIPES(2)) gfx ();
  pipe_frame_painter dut (.CLOCK_50(CLOCK_50), .resetn(resetn), .gfx(gfx));

  int total = 0;
  int bad   = 0;

  logic       cap_plot [NCAP];
  logic [7:0] cap_x    [NCAP];
  logic [6:0] cap_y    [NCAP];
  logic [2:0] cap_c    [NCAP];
  logic       cap_fd   [NCAP];
  logic       cap_ov   [NCAP];
  logic       cap_busy [NCAP];
  logic       exp_plot [NCAP];
  logic [7:0] exp_x    [NCAP];
  logic [6:0] exp_y    [NCAP];
  logic [2:0] exp_c    [NCAP];
  int         exp_len;

  bit         m_valid;
  int         m_by;
  int         m_px [2];
  int         m_gy [2];

  task automatic push(input bit p, input int xx, input int yy, input logic [2:0] c);
    exp_plot[exp_len] = p && (xx < 160) && (yy < 120);
    exp_x[exp_len]    = 8'(xx);
    exp_y[exp_len]    = 7'(yy);
    exp_c[exp_len]    = c;
    exp_len++;
  endtask

  task automatic push_phase(input bit draw);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        push(1'b1, 4 + c, m_by + r, draw ? 3'd6 : 3'd0);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 120; r++)
          push(1'b1, m_px[p] + c, r,
               !draw ? 3'd0 : ((r >= m_gy[p] && r <= m_gy[p] + 31) ? 3'd0 : 3'd2));
  endtask

  // Expected stream: IDLE cycle, optional erase, LATCH cycle, draw, DONE (frame_done) cycle.
  task automatic build_expected(input logic [6:0] by, input logic [15:0] px, input logic [13:0] gy);
    for (int i = 0; i < NCAP; i++) exp_plot[i] = 1'b0;
    exp_len = 0;
    push(1'b0, 0, 0, 3'd0);
    if (m_valid) push_phase(1'b0);
    push(1'b0, 0, 0, 3'd0);
    m_by = int'(by); m_px[0] = int'(px[7:0]); m_px[1] = int'(px[15:8]);
    m_gy[0] = int'(gy[6:0]); m_gy[1] = int'(gy[13:7]); m_valid = 1'b1;
    push_phase(1'b1);
    push(1'b0, 0, 0, 3'd0);
  endtask

  task automatic run_frame(input logic [6:0] by, input logic [15:0] px, input logic [13:0] gy,
                           input int pulse_at, input int toggle_at);
    build_expected(by, px, gy);
    gfx.box_y = by; gfx.pipe_x = px; gfx.pipe_gap_y = gy;
    gfx.game_pulse = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    for (int i = 0; i < exp_len + 4; i++) begin
      cap_plot[i] = gfx.plot; cap_x[i] = gfx.x; cap_y[i] = gfx.y; cap_c[i] = gfx.colour;
      cap_fd[i] = gfx.frame_done; cap_ov[i] = gfx.overrun; cap_busy[i] = gfx.busy;
      gfx.game_pulse = (i == pulse_at);
      if (i == toggle_at) begin
        gfx.box_y = ~by; gfx.pipe_x = ~px; gfx.pipe_gap_y = ~gy;
      end
      @(negedge CLOCK_50);
    end
  endtask

  function automatic int frame_diffs();
    int n = 0;
    for (int i = 0; i < exp_len + 4; i++) begin
      if (cap_plot[i] !== exp_plot[i]) n++;
      else if (exp_plot[i] && ({cap_x[i], cap_y[i], cap_c[i]} !== {exp_x[i], exp_y[i], exp_c[i]})) n++;
      if (cap_fd[i] !== (i == exp_len - 1)) n++;
    end
    return n;
  endfunction

  function automatic int count_plots(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap_plot[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    gfx.game_pulse = 1'b0; gfx.box_y = '0; gfx.pipe_x = '0; gfx.pipe_gap_y = '0;
    repeat (3) @(negedge CLOCK_50);
    total++;
    if ({gfx.plot, gfx.busy} !== 2'b00) begin
      bad++; $display("FAIL reset_plot_busy: got %b want 00", {gfx.plot, gfx.busy});
    end
    total++;
    if ({gfx.x, gfx.y, gfx.colour} !== 18'd0) begin
      bad++; $display("FAIL reset_xyc: got %0d/%0d/%0d want 0/0/0", gfx.x, gfx.y, gfx.colour);
    end
    total++;
    if ({gfx.frame_done, gfx.overrun} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b want 00", {gfx.frame_done, gfx.overrun});
    end
    resetn = 1'b1;
    m_valid = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    total++;
    if ({gfx.plot, gfx.busy} !== 2'b00) begin
      bad++; $display("FAIL idle_quiet: got %b want 00", {gfx.plot, gfx.busy});
    end
    $display("test_reset done");
  endtask

  task automatic test_first_frame();
    run_frame(7'd50, {8'd100, 8'd40}, {7'd60, 7'd20}, -1, -1);
    total++;
    if (frame_diffs() !== 0) begin
      bad++; $display("FAIL first_seq: got %0d bad cycles want 0", frame_diffs());
    end
    total++;
    if ({cap_plot[1], cap_plot[2], cap_x[2], cap_y[2], cap_c[2]} !== {1'b0, 1'b1, 8'd4, 7'd50, 3'd6}) begin
      bad++; $display("FAIL first_pixel: got plot=%b x=%0d y=%0d c=%0d want plot=1 x=4 y=50 c=6",
                      cap_plot[2], cap_x[2], cap_y[2], cap_c[2]);
    end
    total++;
    if ({cap_x[62], cap_y[62], cap_c[62], cap_c[63]} !== {8'd40, 7'd51, 3'd0, 3'd2}) begin
      bad++; $display("FAIL gap_edge: got x=%0d y=%0d c=%0d next_c=%0d want 40 51 0 2",
                      cap_x[62], cap_y[62], cap_c[62], cap_c[63]);
    end
    total++;
    if ({cap_fd[970], cap_fd[971], cap_busy[970], cap_busy[971]} !== 4'b0110) begin
      bad++; $display("FAIL first_done: got fd970/971 busy970/971=%b want 0110",
                      {cap_fd[970], cap_fd[971], cap_busy[970], cap_busy[971]});
    end
    total++;
    if (count_plots(0, 975) !== 969) begin
      bad++; $display("FAIL first_plot_count: got %0d want 969", count_plots(0, 975));
    end
    $display("test_first_frame done");
  endtask

  task automatic test_second_frame();
    run_frame(7'd30, {8'd90, 8'd20}, {7'd10, 7'd70}, -1, -1);
    total++;
    if (frame_diffs() !== 0) begin
      bad++; $display("FAIL second_seq: got %0d bad cycles want 0", frame_diffs());
    end
    total++;
    if ({cap_plot[1], cap_x[1], cap_y[1], cap_c[1]} !== {1'b1, 8'd4, 7'd50, 3'd0}) begin
      bad++; $display("FAIL erase_first: got plot=%b x=%0d y=%0d c=%0d want 1 4 50 0",
                      cap_plot[1], cap_x[1], cap_y[1], cap_c[1]);
    end
    total++;
    if ({cap_plot[970], cap_plot[971], cap_y[971], cap_c[971]} !== {1'b0, 1'b1, 7'd30, 3'd6}) begin
      bad++; $display("FAIL latch_gap: got p970=%b p971=%b y=%0d c=%0d want 0 1 30 6",
                      cap_plot[970], cap_plot[971], cap_y[971], cap_c[971]);
    end
    total++;
    if ({cap_fd[1939], cap_fd[1940]} !== 2'b01) begin
      bad++; $display("FAIL second_done: got %b want 01", {cap_fd[1939], cap_fd[1940]});
    end
    $display("test_second_frame done");
  endtask

  task automatic test_clipping();
    run_frame(7'd118, {8'd158, 8'd60}, {7'd110, 7'd5}, -1, -1);
    total++;
    if (frame_diffs() !== 0) begin
      bad++; $display("FAIL clip_seq: got %0d bad cycles want 0", frame_diffs());
    end
    total++;
    if (count_plots(971, 1939) !== 726) begin
      bad++; $display("FAIL clip_count: got %0d want 726", count_plots(971, 1939));
    end
    total++;
    if ({cap_plot[976], cap_plot[977], cap_plot[1700], cap_fd[1940]} !== 4'b1001) begin
      bad++; $display("FAIL clip_edges: got %b want 1001",
                      {cap_plot[976], cap_plot[977], cap_plot[1700], cap_fd[1940]});
    end
    total++;
    if ({cap_x[1579], cap_y[1579], cap_c[1579], cap_y[1569], cap_c[1569]} !== {8'd158, 7'd119, 3'd0, 7'd109, 3'd2}) begin
      bad++; $display("FAIL clip_gap: got y119 c=%0d y109 c=%0d want 0 2", cap_c[1579], cap_c[1569]);
    end
    $display("test_clipping done");
  endtask

  task automatic test_overrun();
    int n_ov = 0;
    run_frame(7'd118, {8'd158, 8'd60}, {7'd110, 7'd5}, 1500, -1);
    for (int i = 0; i < exp_len + 4; i++) if (cap_ov[i] === 1'b1) n_ov++;
    total++;
    if ({cap_ov[1501], 32'(n_ov)} !== {1'b1, 32'd1}) begin
      bad++; $display("FAIL overrun_pulse: got ov1501=%b count=%0d want 1 1", cap_ov[1501], n_ov);
    end
    total++;
    if (frame_diffs() !== 0) begin
      bad++; $display("FAIL overrun_seq: got %0d bad cycles want 0", frame_diffs());
    end
    total++;
    if (cap_busy[exp_len + 3] !== 1'b0) begin
      bad++; $display("FAIL overrun_no_frame: got busy=%b want 0", cap_busy[exp_len + 3]);
    end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid();
    int n_pl = 0;
    gfx.box_y = 7'd10; gfx.pipe_x = {8'd1, 8'd2}; gfx.pipe_gap_y = {7'd3, 7'd4};
    gfx.game_pulse = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    gfx.game_pulse = 1'b0;
    repeat (300) @(negedge CLOCK_50);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    total++;
    if ({gfx.plot, gfx.busy} !== 2'b00) begin
      bad++; $display("FAIL mid_reset: got plot/busy=%b want 00", {gfx.plot, gfx.busy});
    end
    resetn = 1'b1;
    m_valid = 1'b0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (gfx.plot === 1'b1) n_pl++;
    end
    total++;
    if (n_pl !== 0) begin
      bad++; $display("FAIL mid_reset_quiet: got %0d plots want 0", n_pl);
    end
    run_frame(7'd70, {8'd120, 8'd0}, {7'd40, 7'd90}, -1, -1);
    total++;
    if (frame_diffs() !== 0) begin
      bad++; $display("FAIL post_reset_seq: got %0d bad cycles want 0", frame_diffs());
    end
    total++;
    if ({cap_plot[1], cap_plot[2], cap_y[2], cap_c[2], cap_fd[971]} !== {1'b0, 1'b1, 7'd70, 3'd6, 1'b1}) begin
      bad++; $display("FAIL post_reset_noerase: got p1=%b p2=%b y=%0d c=%0d fd=%b want 0 1 70 6 1",
                      cap_plot[1], cap_plot[2], cap_y[2], cap_c[2], cap_fd[971]);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_input_toggle();
    run_frame(7'd40, {8'd130, 8'd70}, {7'd0, 7'd50}, -1, 972);
    total++;
    if (frame_diffs() !== 0) begin
      bad++; $display("FAIL toggle_seq: got %0d bad cycles want 0", frame_diffs());
    end
    total++;
    if ({cap_y[979], cap_c[979], cap_x[980], cap_c[980]} !== {7'd42, 3'd6, 8'd70, 3'd2}) begin
      bad++; $display("FAIL toggle_latched: got y=%0d c=%0d x=%0d c=%0d want 42 6 70 2",
                      cap_y[979], cap_c[979], cap_x[980], cap_c[980]);
    end
    $display("test_input_toggle done");
  endtask

  initial begin
    gfx.game_pulse = 1'b0;
    gfx.box_y = '0;
    gfx.pipe_x = '0;
    gfx.pipe_gap_y = '0;
    test_reset();
    test_first_frame();
    test_second_frame();
    test_clipping();
    test_overrun();
    test_reset_mid();
    test_input_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_frame_painter.md
Name: pipe_frame_painter

Overview:
- Parametrised successor to the single-pipe line painter for the flappy-box game.
- Each game tick it erases the previous frame's bird box and N pipes, latches new positions, and draws the new frame. Output is a pixel stream (x, y, colour, plot) to the VGA adapter.
- Sits between the game-state logic and the VGA adapter. frame_done tells the game logic the frame is complete.

Parameters:
NUM_PIPES, 2, number of pipes drawn per frame
PIPE_W, 4, pipe width in pixels
GAP_H, 32, vertical gap height in pixels
BOX_SIZE, 3, bird box edge length in pixels
BOX_X, 4, fixed x of the box's left column
SCREEN_W, 160, visible width (x range 0..SCREEN_W-1)
SCREEN_H, 120, visible height (y range 0..SCREEN_H-1)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
game_pulse  in  1  one-cycle frame request
box_y  in  7  top row of bird box
pipe_x  in  8*NUM_PIPES  left column of pipe i at bits [8i+7:8i]
pipe_gap_y  in  7*NUM_PIPES  top row of gap of pipe i at bits [7i+6:7i]
plot  out  1  pixel write strobe
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse at end of draw phase
overrun  out  1  one-cycle pulse when game_pulse arrives while busy

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE.
  - plot, x, y, colour, frame_done, overrun, busy all 0.
  - The `prev_valid` flag is cleared. Reset mid-frame aborts immediately; no further plot pulses.
- States: IDLE, ERASE_BOX, ERASE_PIPES, LATCH, DRAW_BOX, DRAW_PIPES, DONE.
- IDLE:
  - If game_pulse=1: go to ERASE_BOX if prev_valid=1, else go to LATCH.
  - Otherwise stay in IDLE.
- Box phase (ERASE_BOX, DRAW_BOX):
  - Row/column counters scan BOX_SIZE x BOX_SIZE pixels, row-major, one pixel per cycle.
  - Pixel = (BOX_X+col, by+row).
- Pipe phase (ERASE_PIPES, DRAW_PIPES):
  - For pipe 0..NUM_PIPES-1, column 0..PIPE_W-1, row 0..SCREEN_H-1: pixel = (px+col, row).
  - Cycle count = NUM_PIPES*PIPE_W*SCREEN_H.
- Position sources:
  - Erase phases use the latched prev positions.
  - Draw phases use the positions captured in LATCH.
- LATCH: one cycle, plot=0. Captures box_y, pipe_x and pipe_gap_y into the prev registers and sets prev_valid=1.
- Phase order and timing:
  - ERASE_BOX -> ERASE_PIPES -> LATCH -> DRAW_BOX -> DRAW_PIPES -> DONE -> IDLE.
  - Phases are back-to-back with no idle cycles except LATCH.
- Colours:
  - All erase pixels: 3'b000.
  - Draw box: 3'b110.
  - Draw pipe rows with gy <= row <= gy+GAP_H-1: 3'b000.
  - Other draw pipe rows: 3'b010.
- Clipping:
  - A pixel with x >= SCREEN_W or y >= SCREEN_H still consumes its cycle, but with plot=0.
  - Gap arithmetic is done at 8 bits, so gy+GAP_H never wraps.
- Outputs are registered. A pixel scanned in cycle n appears on x/y/colour/plot in cycle n+1.
  - First plot is asserted 2 cycles after the edge that samples game_pulse.
  - plot stays 0 in IDLE, LATCH and DONE.
- frame_done is high for exactly the one cycle following the last draw pixel on the outputs (the DONE state's registered output).
- game_pulse handling:
  - game_pulse while busy=1 is ignored and pulses overrun for one cycle.
  - game_pulse in the same cycle DONE returns to IDLE is also ignored (state != IDLE at the sampling edge).
- Inputs are sampled only in LATCH; changes during the erase and draw phases have no effect.
- Per-frame cycle counts (defaults, E = 9+960 = 969):
  - First frame: 1 (LATCH) + E + DONE.
  - Later frames: E + 1 + E + DONE.

Test Plan:
- Reset then game_pulse, box_y=50, pipe_x={100,40}, pipe_gap_y={60,20}:
  - No erase pixels; 969 contiguous draw cycles.
  - Box pixels (4..6, 50..52) in colour 6.
  - Pipe 0 (x 40..43) colour 0 at y 20..51, colour 2 elsewhere.
  - frame_done pulses once, 971 cycles after the game_pulse edge.
- Second game_pulse with new positions:
  - First 969 plot cycles are black at the old coordinates exactly.
  - Then 1 plot=0 cycle, then the new frame.
- Clipping, pipe_x[1]=158, pipe_gap_y[1]=110, box_y=118:
  - x=160,161 and box row y=120 have plot=0 but cycle count is unchanged.
  - Gap covers y 110..119 for pipe 1 with no wrap.
- game_pulse asserted mid-DRAW_PIPES:
  - overrun pulses 1 cycle; frame continues unaltered.
  - No extra frame starts.
- resetn=0 during ERASE_PIPES:
  - Next cycle plot=0 and busy=0.
  - The following game_pulse skips erase (prev_valid cleared).
- Inputs toggled during DRAW_BOX: drawn pixels match the values latched in LATCH.
